// File: rtl/tdm_demux.sv
// tdm_demux: receive-side time-division demultiplexer.
//   One upstream word stream, interleaved round-robin over N_CH channels with
//   channel 0 marked by up_first_i, is steered into one registered output slot
//   per channel. Each slot has its own valid/ready handshake. Frame alignment
//   is tracked; framing errors pulse sync_err_o and are recovered from.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   up_valid_i     upstream word valid
//   up_first_i     upstream word is the channel-0 word (frame start)
//   up_data_i      upstream word
//   up_ready_o     upstream may transfer this cycle
//   down_valid_o   per-channel slot full
//   down_data_o    per-channel slot data, channel i at [i*W +: W]
//   down_ready_i   per-channel consumer ready
//   locked_o       frame alignment acquired
//   sync_err_o     one-cycle pulse per framing error
//   drop_cnt_o     dropped-word count
//
// Build option: define TDM_DEMUX_DROP_CNT_EN to enable the saturating 16-bit
// dropped-word counter; otherwise drop_cnt_o is tied to zero.
//
// state  | meaning
// HUNT   | no alignment; non-first words dropped, first word locks
// LOCKED | aligned; words routed round-robin from ptr

module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              up_valid_i,
  input  logic              up_first_i,
  input  logic [W-1:0]      up_data_i,
  output logic              up_ready_o,
  output logic [N_CH-1:0]   down_valid_o,
  output logic [N_CH*W-1:0] down_data_o,
  input  logic [N_CH-1:0]   down_ready_i,
  output logic              locked_o,
  output logic              sync_err_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int PW = $clog2(N_CH);
  localparam logic [PW-1:0] LAST = PW'(N_CH - 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, tgt;
  logic [N_CH-1:0] valid_q, valid_d;
  logic [W-1:0]    data_q [N_CH];
  logic            accept, wr_en, err_d, sync_err_q;

  // A frame start always targets slot 0, regardless of where ptr is.
  always_comb tgt = up_first_i ? '0 : ptr_q;

  always_comb begin
    if (state_q == HUNT) up_ready_o = 1'b1;
    else                 up_ready_o = !valid_q[tgt] || down_ready_i[tgt];
  end

  assign accept = up_valid_i && up_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= HUNT;
      ptr_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sync_err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (up_first_i) begin
            wr_en   = 1'b1;
            ptr_d   = PW'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (up_first_i == (ptr_q == '0)) begin
            wr_en = 1'b1;
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
          end else if (up_first_i) begin
            // Early frame start: resync on it; partial frame stays delivered.
            wr_en = 1'b1;
            err_d = 1'b1;
            ptr_d = PW'(1);
          end else begin
            // Missing frame start: drop the word and re-acquire alignment.
            err_d   = 1'b1;
            ptr_d   = '0;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A write wins over a drain on the same slot, so the slot stays full.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      valid_d[i] = valid_q[i];
      if (wr_en && tgt == PW'(i))              valid_d[i] = 1'b1;
      else if (valid_q[i] && down_ready_i[i])  valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < N_CH; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < N_CH; i++)
        if (wr_en && tgt == PW'(i)) data_q[i] <= up_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) down_data_o[i*W +: W] = data_q[i];
  end

  assign down_valid_o = valid_q;
  assign locked_o     = (state_q == LOCKED);
  assign sync_err_o   = sync_err_q;

`ifdef TDM_DEMUX_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  // Non-first word while hunting, or non-first word where a frame start was due.
  assign drop = accept && !up_first_i && (state_q == HUNT || ptr_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Sequential time-division demultiplexer, the receive-side counterpart of the combinational mux primitives in this section.
- Takes one upstream stream of words interleaved round-robin across N_CH channels, with channel 0 marked by up_first.
- Steers each accepted word into a one-entry registered output slot for its channel; each slot has its own valid/ready handshake.
- Tracks frame alignment; flags and recovers from framing errors.

Parameters:
N_CH, 4, number of output channels (>=2)
W, 8, data word width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
up_valid  input  1  upstream word valid
up_first  input  1  qualifies up_data as channel-0 word (frame start)
up_data  input  W  upstream word
up_ready  output  1  upstream may transfer this cycle
down_valid  output  N_CH  per-channel output slot full
down_data  output  N_CH*W  channel i occupies bits [i*W +: W]
down_ready  input  N_CH  per-channel consumer ready
locked  output  1  frame alignment acquired
sync_err  output  1  one-cycle pulse on framing error
drop_cnt  output  16  dropped-word count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=HUNT, ptr=0, down_valid=0, down_data=0, locked=0, sync_err=0, drop_cnt=0. Reset mid-operation discards all buffered words immediately.
- Upstream transfer: accept = up_valid && up_ready. Downstream transfer on channel i: down_valid[i] && down_ready[i].
- Target channel: tgt = up_first ? 0 : ptr.
- up_ready:
  - HUNT: 1.
  - LOCKED: !down_valid[tgt] || down_ready[tgt].
  - Combinational from up_first, state, ptr, down_valid, down_ready. Must not depend on up_valid.
- Slot update per channel i:
  - Written words go to slot tgt.
  - If a write and a drain hit the same slot in the same cycle, down_valid stays 1 and down_data takes the new word.
  - Drain without write: down_valid[i] -> 0. down_data holds its value.
- Latency: a word accepted in cycle t is visible on down_valid/down_data at t+1.
- States:
  - HUNT (locked=0):
    - Accepted word with up_first=0 is dropped; counts as drop.
    - Accepted word with up_first=1 is written to slot 0; ptr <- 1; go to LOCKED.
  - LOCKED (locked=1), per accepted word:
    - up_first == (ptr==0): normal. Write slot tgt; ptr <- (ptr+1) mod N_CH.
    - up_first=1, ptr!=0 (early frame start): sync_err=1 next cycle. Write slot 0; ptr <- 1; stay LOCKED. Partial frame already delivered is not retracted.
    - up_first=0, ptr==0 (missing frame start): sync_err=1 next cycle. Word dropped (counts as drop); go to HUNT; ptr <- 0. Slots keep their contents and drain normally.
- ptr wraps N_CH-1 -> 0. N_CH need not be a power of 2.
- sync_err is registered: high exactly one cycle per error event.
- No accept means no change to ptr or state. Stalls (up_ready=0) may last indefinitely; upstream must hold data stable.

Optional Feature:
- Macro: TDM_DEMUX_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter, incremented once per dropped word (HUNT non-first words, LOCKED missing-frame-start words). Saturates at 16'hFFFF. Cleared only by reset.
- Undefined: drop_cnt tied to 16'h0000; no counter logic. Port list is identical in both builds.

Test Plan:
- Lock and route:
  - Stimulus: after reset, N_CH=4, all down_ready=1. Send 0x10(first), 0x11, 0x12, 0x13, 0x20(first) back-to-back.
  - Response: locked=1 from the cycle after 0x10. Slots 0..3 receive 0x10..0x13, each one cycle after acceptance. Slot 0 then gets 0x20. sync_err never asserted.
- Hunt drop:
  - Stimulus: after reset, send 0xAA, 0xBB (up_first=0), then 0x01(first).
  - Response: 0xAA and 0xBB appear on no channel; up_ready=1 throughout. drop_cnt=2 with macro, 0 without. 0x01 lands in slot 0.
- Backpressure:
  - Stimulus: locked, ptr=2, down_valid[2]=1, down_ready[2]=0, send 0x55.
  - Response: up_ready=0 while stalled. When down_ready[2]=1, 0x55 is accepted in that same cycle, down_valid[2] stays 1, down_data[2] becomes 0x55.
- Early frame start:
  - Stimulus: locked, send 0x30(first), 0x31, 0x40(first).
  - Response: sync_err pulses one cycle. 0x40 goes to slot 0; the next non-first word goes to slot 1; locked stays 1.
- Missing frame start:
  - Stimulus: locked, send a full frame, then 0x77 with up_first=0 at ptr=0.
  - Response: sync_err pulse; locked=0 next cycle; 0x77 dropped; drop_cnt increments by 1 (macro defined).
- Async reset mid-frame:
  - Stimulus: locked with slots 1 and 3 full; drive rst=0 between clock edges.
  - Response: down_valid=0, locked=0, drop_cnt=0 immediately, without waiting for a clock edge.
